// File: rtl/tlb_if.sv
// Bundle between the MIPS32 pipeline/cp0 and the joint TLB: two search ports,
// the TLBWI/TLBWR write port and the TLBR read port.
interface tlb_if #(
  parameter int TLBNUM       = 16,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
);
  // search port 0 (fetch)
  logic [18:0]             s0_vpn2;
  logic                    s0_odd_page;
  logic [7:0]              s0_asid;
  logic                    s0_found;
  logic [TLBNUM_WIDTH-1:0] s0_index;
  logic [19:0]             s0_pfn;
  logic [2:0]              s0_c;
  logic                    s0_d;
  logic                    s0_v;

  // search port 1 (data access / TLBP)
  logic [18:0]             s1_vpn2;
  logic                    s1_odd_page;
  logic [7:0]              s1_asid;
  logic                    s1_found;
  logic [TLBNUM_WIDTH-1:0] s1_index;
  logic [19:0]             s1_pfn;
  logic [2:0]              s1_c;
  logic                    s1_d;
  logic                    s1_v;

  // write port
  logic                    we;
  logic [TLBNUM_WIDTH-1:0] w_index;
  logic [18:0]             w_vpn2;
  logic [7:0]              w_asid;
  logic                    w_g;
  logic [19:0]             w_pfn0;
  logic [2:0]              w_c0;
  logic                    w_d0;
  logic                    w_v0;
  logic [19:0]             w_pfn1;
  logic [2:0]              w_c1;
  logic                    w_d1;
  logic                    w_v1;

  // read port
  logic [TLBNUM_WIDTH-1:0] r_index;
  logic [18:0]             r_vpn2;
  logic [7:0]              r_asid;
  logic                    r_g;
  logic [19:0]             r_pfn0;
  logic [2:0]              r_c0;
  logic                    r_d0;
  logic                    r_v0;
  logic [19:0]             r_pfn1;
  logic [2:0]              r_c1;
  logic                    r_d1;
  logic                    r_v1;

  modport master (
    output s0_vpn2, s0_odd_page, s0_asid,
    input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    output s1_vpn2, s1_odd_page, s1_asid,
    input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    output we, w_index, w_vpn2, w_asid, w_g,
    output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    output r_index,
    input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
  );

  modport slave (
    input  s0_vpn2, s0_odd_page, s0_asid,
    output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    input  s1_vpn2, s1_odd_page, s1_asid,
    output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    input  we, w_index, w_vpn2, w_asid, w_g,
    input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    input  r_index,
    output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
  );
endinterface

// File: rtl/tlb.sv
// Fully-associative joint TLB of paired even/odd pages with two independent
// zero-latency search ports, one write port and one combinational read port.
module tlb #(
  parameter int TLBNUM       = 16,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
  input logic   clk,
  input logic   reset,
  tlb_if.slave  bus
);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } entry_t;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } page_t;

  entry_t                  tlb_q [TLBNUM];
  entry_t                  w_entry;
  entry_t                  r_entry;
  entry_t                  s0_entry;
  entry_t                  s1_entry;
  logic [TLBNUM-1:0]       match0;
  logic [TLBNUM-1:0]       match1;
  logic                    hit0;
  logic                    hit1;
  logic [TLBNUM_WIDTH-1:0] idx0;
  logic [TLBNUM_WIDTH-1:0] idx1;
  page_t                   page0;
  page_t                   page1;

  // Lowest set bit wins so that duplicate entries resolve deterministically.
  function automatic logic [TLBNUM_WIDTH-1:0] first_set(input logic [TLBNUM-1:0] m);
    logic [TLBNUM_WIDTH-1:0] idx;
    idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (m[i]) idx = TLBNUM_WIDTH'(i);
    end
    return idx;
  endfunction

  function automatic page_t pick_page(input entry_t e, input logic odd, input logic hit);
    page_t p;
    p = '0;
    if (hit) begin
      if (odd) p = '{pfn: e.pfn1, c: e.c1, d: e.d1, v: e.v1};
      else     p = '{pfn: e.pfn0, c: e.c0, d: e.d0, v: e.v0};
    end
    return p;
  endfunction

  assign w_entry = '{
    vpn2: bus.w_vpn2, asid: bus.w_asid, g: bus.w_g,
    pfn0: bus.w_pfn0, c0: bus.w_c0, d0: bus.w_d0, v0: bus.w_v0,
    pfn1: bus.w_pfn1, c1: bus.w_c1, d1: bus.w_d1, v1: bus.w_v1
  };

  // Entry storage; reset takes precedence over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) tlb_q[i] <= '0;
    end else if (bus.we) begin
      tlb_q[bus.w_index] <= w_entry;
    end
  end

  // Valid bits deliberately do not gate the match; v=0 hits report "invalid".
  for (genvar i = 0; i < TLBNUM; i++) begin : g_match
    assign match0[i] = (tlb_q[i].vpn2 == bus.s0_vpn2) &&
                       (tlb_q[i].g || (tlb_q[i].asid == bus.s0_asid));
    assign match1[i] = (tlb_q[i].vpn2 == bus.s1_vpn2) &&
                       (tlb_q[i].g || (tlb_q[i].asid == bus.s1_asid));
  end

  always_comb begin
    hit0     = |match0;
    idx0     = first_set(match0);
    s0_entry = tlb_q[idx0];
    page0    = pick_page(s0_entry, bus.s0_odd_page, hit0);
  end

  always_comb begin
    hit1     = |match1;
    idx1     = first_set(match1);
    s1_entry = tlb_q[idx1];
    page1    = pick_page(s1_entry, bus.s1_odd_page, hit1);
  end

  assign bus.s0_found = hit0;
  assign bus.s0_index = idx0;
  assign bus.s0_pfn   = page0.pfn;
  assign bus.s0_c     = page0.c;
  assign bus.s0_d     = page0.d;
  assign bus.s0_v     = page0.v;

  assign bus.s1_found = hit1;
  assign bus.s1_index = idx1;
  assign bus.s1_pfn   = page1.pfn;
  assign bus.s1_c     = page1.c;
  assign bus.s1_d     = page1.d;
  assign bus.s1_v     = page1.v;

  assign r_entry    = tlb_q[bus.r_index];
  assign bus.r_vpn2 = r_entry.vpn2;
  assign bus.r_asid = r_entry.asid;
  assign bus.r_g    = r_entry.g;
  assign bus.r_pfn0 = r_entry.pfn0;
  assign bus.r_c0   = r_entry.c0;
  assign bus.r_d0   = r_entry.d0;
  assign bus.r_v0   = r_entry.v0;
  assign bus.r_pfn1 = r_entry.pfn1;
  assign bus.r_c1   = r_entry.c1;
  assign bus.r_d1   = r_entry.d1;
  assign bus.r_v1   = r_entry.v1;

endmodule

// File: tb/tb_tlb.sv
// Directed bench for tlb: table of search vectors plus hand sequences for
// write visibility, global pages, duplicates, read port and reset-vs-write.
module tb_tlb;
  localparam int NW = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  tlb_if #(.TLBNUM(16)) bus ();
  tlb #(.TLBNUM(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          port;
    logic [18:0] vpn2;
    logic        odd;
    logic [7:0]  asid;
    logic        found;
    logic [3:0]  idx;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic wr(input logic [NW-1:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                    input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                    input logic d0, input logic v0, input logic [19:0] pfn1,
                    input logic [2:0] c1, input logic d1, input logic v1);
    bus.we      = 1'b1;
    bus.w_index = idx;
    bus.w_vpn2  = vpn2;
    bus.w_asid  = asid;
    bus.w_g     = g;
    bus.w_pfn0  = pfn0;
    bus.w_c0    = c0;
    bus.w_d0    = d0;
    bus.w_v0    = v0;
    bus.w_pfn1  = pfn1;
    bus.w_c1    = c1;
    bus.w_d1    = d1;
    bus.w_v1    = v1;
  endtask

  task automatic s0(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    bus.s0_vpn2 = vpn2; bus.s0_odd_page = odd; bus.s0_asid = asid;
  endtask

  task automatic s1(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    bus.s1_vpn2 = vpn2; bus.s1_odd_page = odd; bus.s1_asid = asid;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    wr(4'd0, 19'd0, 8'd0, 1'b0, 20'd0, 3'd0, 1'b0, 1'b0, 20'd0, 3'd0, 1'b0, 1'b0);
    bus.we = 1'b0;
    bus.r_index = '0;
    s0(19'd0, 1'b0, 8'd0);
    s1(19'h12345, 1'b0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state: every entry is zero, so vpn2=0/asid=0 hits entry 0 with v=0
    #1;
    chk("rst_s0_found", 32'(bus.s0_found), 32'd1);
    chk("rst_s0_index", 32'(bus.s0_index), 32'd0);
    chk("rst_s0_v", 32'(bus.s0_v), 32'd0);
    chk("rst_s1_found", 32'(bus.s1_found), 32'd0);
    chk("rst_s1_outs", 32'({bus.s1_index, bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v}), 32'd0);
    chk("rst_tlbp", 32'({~bus.s1_found, bus.s1_index}), 32'h10);

    // Write entry 5; a same-cycle search must still see the old contents
    wr(4'd5, 19'h40001, 8'h12, 1'b0, 20'hAAAAA, 3'd3, 1'b1, 1'b1, 20'h55555, 3'd5, 1'b0, 1'b0);
    s1(19'h40001, 1'b0, 8'h12);
    #1;
    chk("wr_same_cycle_found", 32'(bus.s1_found), 32'd0);
    tick();

    vecs[0] = '{"e5_even",     1'b1, 19'h40001, 1'b0, 8'h12, 1'b1, 4'd5, 20'hAAAAA, 3'd3, 1'b1, 1'b1};
    vecs[1] = '{"e5_odd",      1'b1, 19'h40001, 1'b1, 8'h12, 1'b1, 4'd5, 20'h55555, 3'd5, 1'b0, 1'b0};
    vecs[2] = '{"e5_port0",    1'b0, 19'h40001, 1'b0, 8'h12, 1'b1, 4'd5, 20'hAAAAA, 3'd3, 1'b1, 1'b1};
    vecs[3] = '{"e5_bad_asid", 1'b1, 19'h40001, 1'b0, 8'h13, 1'b0, 4'd0, 20'h0,     3'd0, 1'b0, 1'b0};
    vecs[4] = '{"zero_hit",    1'b0, 19'h00000, 1'b1, 8'h00, 1'b1, 4'd0, 20'h0,     3'd0, 1'b0, 1'b0};
    vecs[5] = '{"zero_asid1",  1'b0, 19'h00000, 1'b0, 8'h01, 1'b0, 4'd0, 20'h0,     3'd0, 1'b0, 1'b0};
    vecs[6] = '{"near_vpn",    1'b1, 19'h40000, 1'b0, 8'h12, 1'b0, 4'd0, 20'h0,     3'd0, 1'b0, 1'b0};

    for (int k = 0; k < 7; k++) begin
      if (vecs[k].port) s1(vecs[k].vpn2, vecs[k].odd, vecs[k].asid);
      else              s0(vecs[k].vpn2, vecs[k].odd, vecs[k].asid);
      #1;
      if (vecs[k].port)
        chk(vecs[k].name, 32'({bus.s1_found, bus.s1_index, bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v}),
            32'({vecs[k].found, vecs[k].idx, vecs[k].pfn, vecs[k].c, vecs[k].d, vecs[k].v}));
      else
        chk(vecs[k].name, 32'({bus.s0_found, bus.s0_index, bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v}),
            32'({vecs[k].found, vecs[k].idx, vecs[k].pfn, vecs[k].c, vecs[k].d, vecs[k].v}));
    end

    // Global page: a foreign ASID now hits on both ports at once
    wr(4'd5, 19'h40001, 8'h12, 1'b1, 20'hAAAAA, 3'd3, 1'b1, 1'b1, 20'h55555, 3'd5, 1'b0, 1'b0);
    tick();
    s0(19'h40001, 1'b0, 8'h13);
    s1(19'h40001, 1'b1, 8'h13);
    #1;
    chk("g_s0", 32'({bus.s0_found, bus.s0_index, bus.s0_pfn}), 32'({1'b1, 4'd5, 20'hAAAAA}));
    chk("g_s1", 32'({bus.s1_found, bus.s1_index, bus.s1_pfn, bus.s1_v}), 32'({1'b1, 4'd5, 20'h55555, 1'b0}));
    chk("g_tlbp", 32'({~bus.s1_found, bus.s1_index}), 32'h05);

    // Read port, then a write that is only visible on the next cycle
    bus.r_index = 4'd5;
    #1;
    chk("r_vpn2", 32'(bus.r_vpn2), 32'h40001);
    chk("r_asid_g", 32'({bus.r_asid, bus.r_g}), 32'({8'h12, 1'b1}));
    chk("r_even", 32'({bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0}), 32'({20'hAAAAA, 3'd3, 1'b1, 1'b1}));
    chk("r_odd", 32'({bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1}), 32'({20'h55555, 3'd5, 1'b0, 1'b0}));
    wr(4'd5, 19'h40001, 8'h12, 1'b1, 20'h00001, 3'd3, 1'b1, 1'b1, 20'h55555, 3'd5, 1'b0, 1'b0);
    #1;
    chk("r_pfn0_old", 32'(bus.r_pfn0), 32'hAAAAA);
    tick();
    chk("r_pfn0_new", 32'(bus.r_pfn0), 32'h00001);

    // Duplicates: the lower index wins until it is moved away
    wr(4'd9, 19'h2ABCD, 8'h44, 1'b0, 20'h00009, 3'd1, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    tick();
    wr(4'd3, 19'h2ABCD, 8'h44, 1'b0, 20'h00003, 3'd2, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    tick();
    s0(19'h2ABCD, 1'b0, 8'h44);
    #1;
    chk("dup_lo", 32'({bus.s0_found, bus.s0_index, bus.s0_pfn}), 32'({1'b1, 4'd3, 20'h00003}));
    wr(4'd3, 19'h7FFFF, 8'h00, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("dup_hi", 32'({bus.s0_found, bus.s0_index, bus.s0_pfn}), 32'({1'b1, 4'd9, 20'h00009}));

    // Reset wins over a coincident write
    wr(4'd9, 19'h11111, 8'h44, 1'b1, 20'hFFFFF, 3'd7, 1'b1, 1'b1, 20'hFFFFF, 3'd7, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.r_index = 4'd9;
    s0(19'h2ABCD, 1'b0, 8'h44);
    s1(19'h40001, 1'b0, 8'h13);
    #1;
    chk("rw_s0_gone", 32'(bus.s0_found), 32'd0);
    chk("rw_s1_gone", 32'({bus.s1_found, bus.s1_index, bus.s1_pfn}), 32'd0);
    chk("rw_r9", 32'({bus.r_vpn2, bus.r_g, bus.r_v0, bus.r_v1}), 32'd0);
    chk("rw_r9_pfn", 32'(bus.r_pfn1), 32'd0);
    s0(19'h11111, 1'b0, 8'h44);
    #1;
    chk("rw_no_write", 32'(bus.s0_found), 32'd0);
    s0(19'd0, 1'b1, 8'd0);
    #1;
    chk("rw_zero_hit", 32'({bus.s0_found, bus.s0_index}), 32'({1'b1, 4'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tlb.md
Name: tlb

Overview:
- Fully-associative joint TLB for the MIPS32 core. It holds TLBNUM entries of paired even/odd pages.
- Two search ports serve translation and TLBP. Port 0 is used by pre-IF/IF fetch; port 1 is used by EX/MEM data access and TLBP.
- It consumes the write-port bundle (TLBWI/TLBWR) that cp0 drives from EntryHi/EntryLo0/1/Index/Random.
- It drives the read-port bundle back to cp0 for TLBR.

Parameters:
- TLBNUM, 16, number of entries (power of two, 2..64).
- TLBNUM_WIDTH, $clog2(TLBNUM), index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s0_vpn2  in  19  fetch VA[31:13]
- s0_odd_page  in  1  fetch VA[12]
- s0_asid  in  8  current ASID
- s0_found  out  1  some entry matched
- s0_index  out  TLBNUM_WIDTH  matched entry index
- s0_pfn  out  20  selected page PFN
- s0_c  out  3  selected page cache attribute
- s0_d  out  1  selected page dirty
- s0_v  out  1  selected page valid
- s1_vpn2, s1_odd_page, s1_asid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v  same widths and meanings as port 0, for data access / TLBP
- we  in  1  write strobe (TLBWI or TLBWR retiring in WB)
- w_index  in  TLBNUM_WIDTH  entry written
- w_vpn2  in  19  write data
- w_asid  in  8  write data
- w_g  in  1  write data
- w_pfn0  in  20  write data
- w_c0  in  3  write data
- w_d0  in  1  write data
- w_v0  in  1  write data
- w_pfn1  in  20  write data
- w_c1  in  3  write data
- w_d1  in  1  write data
- w_v1  in  1  write data
- r_index  in  TLBNUM_WIDTH  entry read
- r_vpn2  out  19  contents of entry r_index
- r_asid  out  8  contents of entry r_index
- r_g  out  1  contents of entry r_index
- r_pfn0  out  20  contents of entry r_index
- r_c0  out  3  contents of entry r_index
- r_d0  out  1  contents of entry r_index
- r_v0  out  1  contents of entry r_index
- r_pfn1  out  20  contents of entry r_index
- r_c1  out  3  contents of entry r_index
- r_d1  out  1  contents of entry r_index
- r_v1  out  1  contents of entry r_index

Behaviour:
- Storage: per-entry registers vpn2, asid, g, pfn0/1, c0/1, d0/1, v0/1. Register array, no RAM inference.
- Reset: every field of every entry is cleared to 0, including g, v0 and v1.
- Write:
  - On the posedge with we=1, entry w_index takes all w_* fields.
  - The write is visible to searches and reads from the next cycle onward.
  - A same-cycle search or read returns the old contents.
  - If reset and we are both asserted, reset wins.
- Match, per entry i: (vpn2[i]==sN_vpn2) && (g[i] || asid[i]==sN_asid). The valid bits do not gate the match.
- Search outputs are purely combinational, with zero latency.
  - sN_found = OR of matches.
  - sN_index = lowest matching index (priority encoder). Multiple matches are software error, but the result must be deterministic.
  - Page fields come from the odd half (pfn1/c1/d1/v1) when sN_odd_page=1, else from the even half.
  - No match: found=0 and index/pfn/c/d/v are all 0.
- The two search ports are fully independent and may hit the same or different entries in the same cycle.
- cp0 TLBP result is {~s1_found, s1_index}. The MSB is the Index.P bit, which cp0 latches.
- Read port: combinational, with r_g = g[r_index].
- Exception classification stays with the consumer:
  - found=0 means refill.
  - found=1 with v=0 means invalid.
  - A store with d=0 means Mod.
- Out-of-range w_index/r_index cannot occur because widths are exact.

Test Plan:
- Reset, then search port 0 with vpn2=0, asid=0 → s0_found=1, index=0, v=0 (all entries zero). Port 1 with vpn2=0x12345 → found=0, all outputs 0.
- Write entry 5: vpn2=0x40001, asid=0x12, g=0, pfn0=0xAAAAA, c0=3, d0=1, v0=1, pfn1=0x55555, v1=0.
  - Same cycle, s1 with that vpn2/asid → found=0.
  - Next cycle → found=1, index=5, pfn=0xAAAAA, c=3, d=1, v=1.
  - Next cycle with odd_page=1 → pfn=0x55555, v=0.
- ASID/global: entry 5 searched with asid=0x13 → found=0. Rewrite entry 5 with g=1 → asid=0x13 now hits on both ports simultaneously.
- Duplicate: write the identical vpn2/asid into entries 9 and 3 → s0_index=3. Clear entry 3 (vpn2=0x7FFFF) → s0_index=9.
- Read: r_index=5 after the write returns all written fields.
  - Write entry 5 with new pfn0=0x1 while r_index=5 → r_pfn0 still 0xAAAAA that cycle, 0x1 next cycle.
- Reset mid-traffic: we=1 and reset=1 on the same edge → entry contents are all 0 afterward; prior hits disappear.
